// File: rtl/spi_ram_bridge.sv
// SPI slave with an integrated single-port RAM, driven by 2-bit commands with variable-length payloads.
// Optional feature: define SPI_RAM_AUTO_INC_EN to post-increment wr_addr/rd_addr on every data access.
module spi_ram_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 2 ** ADDR_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic frame_done,
    output logic frame_err,
    output logic busy
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int IW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [CW-1:0]       A_BITS = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0]       D_BITS = CW'(DATA_WIDTH);
    localparam logic [CW-1:0]       D_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH  = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] CMD        = 3'd1;
    localparam logic [2:0] RX_PAYLOAD = 3'd2;
    localparam logic [2:0] RD_WAIT    = 3'd3;
    localparam logic [2:0] TX         = 3'd4;
    localparam logic [2:0] DONE       = 3'd5;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;

`ifdef SPI_RAM_AUTO_INC_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    // Wraps at the top of the RAM; out-of-range addresses wrap naturally at 2**ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
    endfunction
`endif

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            cmd_q, cmd_d;
    logic [MAXW-1:0]       shreg_q, shreg_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  miso_q, miso_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_in_range;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_we;
    logic [CW-1:0]         p_bits;

    // One shared address port: reads happen only in RD_WAIT, writes only at a WR_DATA commit.
    always_comb begin
        mem_addr     = (state_q == RD_WAIT) ? rd_addr_q : wr_addr_q;
        mem_in_range = ({1'b0, mem_addr} < DEPTH);
        mem_rdata    = mem_in_range ? mem[mem_addr[IW-1:0]] : '0;
        p_bits       = (cmd_q == CMD_WR_DATA) ? D_BITS : A_BITS;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        shreg_d   = shreg_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        miso_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!SS_n) begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
            end
            CMD: begin
                if (SS_n) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cmd_d = {cmd_q[0], MOSI};
                    if (cnt_q == '0) begin
                        cnt_d = CW'(1);
                    end else begin
                        cnt_d   = '0;
                        state_d = (cmd_q[0] && MOSI) ? RD_WAIT : RX_PAYLOAD;
                    end
                end
            end
            RX_PAYLOAD: begin
                // The edge after the last payload bit commits even if SS_n has already risen.
                if (cnt_q == p_bits) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                    case (cmd_q)
                        CMD_WR_ADDR: wr_addr_d = shreg_q[ADDR_WIDTH-1:0];
                        CMD_WR_DATA: begin
                            mem_we = rst_n && mem_in_range;
`ifdef SPI_RAM_AUTO_INC_EN
                            wr_addr_d = next_addr(wr_addr_q);
`endif
                        end
                        CMD_RD_ADDR: rd_addr_d = shreg_q[ADDR_WIDTH-1:0];
                        default: ;
                    endcase
                end else if (SS_n) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    shreg_d = {shreg_q[MAXW-2:0], MOSI};
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            RD_WAIT: begin
                if (SS_n) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    shreg_d                 = '0;
                    shreg_d[DATA_WIDTH-1:0] = mem_rdata;
                    cnt_d                   = '0;
                    state_d                 = TX;
`ifdef SPI_RAM_AUTO_INC_EN
                    rd_addr_d = next_addr(rd_addr_q);
`endif
                end
            end
            TX: begin
                if (SS_n) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    miso_d  = shreg_q[DATA_WIDTH-1];
                    shreg_d = {shreg_q[MAXW-2:0], 1'b0};
                    if (cnt_q == D_LAST) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                if (SS_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            shreg_q   <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            miso_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            shreg_q   <= shreg_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            miso_q    <= miso_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr[IW-1:0]] <= shreg_q[DATA_WIDTH-1:0];
    end

    assign MISO       = miso_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Testbench for spi_ram_bridge: a full-size RAM and a 200-word RAM share the same SPI stimulus.
module tb_spi_ram_bridge;

    logic clk = 1'b0;
    logic rst_n;
    logic SS_n;
    logic MOSI;
    logic miso_a, done_a, err_a, busy_a;
    logic miso_b, done_b, err_b, busy_b;

    int pass_count  = 0;
    int check_count = 0;

    always #5 clk = ~clk;

    spi_ram_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256)) dut_full (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(miso_a), .frame_done(done_a), .frame_err(err_a), .busy(busy_a)
    );

    spi_ram_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(200)) dut_small (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(miso_b), .frame_done(done_b), .frame_err(err_b), .busy(busy_b)
    );

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] payload;
        logic [7:0] exp_full;
        logic [7:0] exp_small;
    } vec_t;

    vec_t vecs[14];

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
    endtask

    // Drive on the falling edge so the DUT samples stable lines, then settle past the rising edge.
    task automatic do_edge(input logic ss, input logic mosi, inout int dc, inout int ec);
        @(negedge clk);
        SS_n = ss;
        MOSI = mosi;
        @(posedge clk);
        #1;
        dc += int'(done_a);
        ec += int'(err_a);
    endtask

    // One complete frame, followed by extra_low held-low cycles and SS_n release.
    task automatic apply_stimulus(input logic [1:0] cmd, input logic [7:0] payload, input int extra_low,
                                  output logic [7:0] rd_full, output logic [7:0] rd_small,
                                  output int dc, output int ec);
        rd_full  = '0;
        rd_small = '0;
        dc = 0;
        ec = 0;
        do_edge(1'b0, 1'b0, dc, ec);
        do_edge(1'b0, cmd[1], dc, ec);
        do_edge(1'b0, cmd[0], dc, ec);
        if (cmd != 2'b11) begin
            for (int i = 7; i >= 0; i--) do_edge(1'b0, payload[i], dc, ec);
            do_edge(1'b0, 1'b0, dc, ec);
        end else begin
            do_edge(1'b0, 1'b0, dc, ec);
            for (int k = 0; k < 8; k++) begin
                do_edge(1'b0, 1'b0, dc, ec);
                rd_full[7-k]  = miso_a;
                rd_small[7-k] = miso_b;
            end
        end
        for (int i = 0; i < extra_low; i++) do_edge(1'b0, i[0], dc, ec);
        do_edge(1'b1, 1'b0, dc, ec);
        do_edge(1'b1, 1'b0, dc, ec);
    endtask

    task automatic read_back(input logic [7:0] addr, input logic [7:0] exp_full, input logic [7:0] exp_small,
                             input string name);
        logic [7:0] rf, rs;
        int dc, ec;
        apply_stimulus(2'b10, addr, 0, rf, rs, dc, ec);
        apply_stimulus(2'b11, 8'h00, 0, rf, rs, dc, ec);
        check_output({name, "_full"}, rf, exp_full);
        check_output({name, "_small"}, rs, exp_small);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rf, rs;
        int dc, ec;

        vecs[0]  = '{2'b00, 8'h3C, 8'h00, 8'h00};
        vecs[1]  = '{2'b01, 8'hA5, 8'h00, 8'h00};
        vecs[2]  = '{2'b10, 8'h3C, 8'h00, 8'h00};
        vecs[3]  = '{2'b11, 8'h00, 8'hA5, 8'hA5};
        vecs[4]  = '{2'b00, 8'hC8, 8'h00, 8'h00};
        vecs[5]  = '{2'b01, 8'h11, 8'h00, 8'h00};
        vecs[6]  = '{2'b10, 8'hC8, 8'h00, 8'h00};
        vecs[7]  = '{2'b11, 8'h00, 8'h11, 8'h00};
        vecs[8]  = '{2'b00, 8'h00, 8'h00, 8'h00};
        vecs[9]  = '{2'b01, 8'h5A, 8'h00, 8'h00};
        vecs[10] = '{2'b10, 8'h00, 8'h00, 8'h00};
        vecs[11] = '{2'b11, 8'h00, 8'h5A, 8'h5A};
        vecs[12] = '{2'b10, 8'h3C, 8'h00, 8'h00};
        vecs[13] = '{2'b11, 8'h00, 8'hA5, 8'hA5};

        rst_n = 1'b0;
        SS_n  = 1'b1;
        MOSI  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_miso", {7'b0, miso_a}, 8'h00);
        check_output("reset_done", {7'b0, done_a}, 8'h00);
        check_output("reset_err", {7'b0, err_a}, 8'h00);
        check_output("reset_busy", {7'b0, busy_a}, 8'h00);
        check_output("reset_busy_small", {7'b0, busy_b}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            apply_stimulus(vecs[v].cmd, vecs[v].payload, 0, rf, rs, dc, ec);
            check_output($sformatf("vec%0d_done", v), 8'(dc), 8'd1);
            check_output($sformatf("vec%0d_err", v), 8'(ec), 8'd0);
            if (vecs[v].cmd == 2'b11) begin
                check_output($sformatf("vec%0d_rd_full", v), rf, vecs[v].exp_full);
                check_output($sformatf("vec%0d_rd_small", v), rs, vecs[v].exp_small);
            end
        end

        // SS_n held low past the commit must not produce a second commit.
        apply_stimulus(2'b00, 8'h3C, 5, rf, rs, dc, ec);
        check_output("hold_low_done", 8'(dc), 8'd1);
        check_output("hold_low_err", 8'(ec), 8'd0);

        // Reset in the middle of a WR_DATA payload discards the frame.
        dc = 0;
        ec = 0;
        do_edge(1'b0, 1'b0, dc, ec);
        do_edge(1'b0, 1'b0, dc, ec);
        do_edge(1'b0, 1'b1, dc, ec);
        for (int i = 0; i < 3; i++) do_edge(1'b0, 1'b0, dc, ec);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("midrst_miso", {7'b0, miso_a}, 8'h00);
        check_output("midrst_busy", {7'b0, busy_a}, 8'h00);
        check_output("midrst_done", {7'b0, done_a}, 8'h00);
        check_output("midrst_err", {7'b0, err_a}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        SS_n  = 1'b1;
        @(posedge clk);
        #1;
        ec += int'(err_a);
        check_output("midrst_no_err", 8'(ec), 8'd0);
        read_back(8'h3C, 8'hA5, 8'hA5, "midrst_mem");

        // SS_n rising at edge 7 of a WR_DATA 0xFF frame aborts it.
        apply_stimulus(2'b00, 8'h3C, 0, rf, rs, dc, ec);
        dc = 0;
        ec = 0;
        do_edge(1'b0, 1'b0, dc, ec);
        do_edge(1'b0, 1'b0, dc, ec);
        do_edge(1'b0, 1'b1, dc, ec);
        for (int i = 0; i < 3; i++) do_edge(1'b0, 1'b1, dc, ec);
        check_output("abort_err_before", 8'(ec), 8'd0);
        do_edge(1'b1, 1'b1, dc, ec);
        check_output("abort_err_pulse", {7'b0, err_a}, 8'h01);
        check_output("abort_busy", {7'b0, busy_a}, 8'h00);
        do_edge(1'b1, 1'b0, dc, ec);
        check_output("abort_err_clear", {7'b0, err_a}, 8'h00);
        check_output("abort_no_done", 8'(dc), 8'd0);
        read_back(8'h3C, 8'hA5, 8'hA5, "abort_mem");

        // Back-to-back WR_DATA at the top address.
        apply_stimulus(2'b00, 8'hFF, 0, rf, rs, dc, ec);
        apply_stimulus(2'b01, 8'h01, 0, rf, rs, dc, ec);
        apply_stimulus(2'b01, 8'h02, 0, rf, rs, dc, ec);
`ifdef SPI_RAM_AUTO_INC_EN
        read_back(8'hFF, 8'h01, 8'h00, "inc_top");
        read_back(8'h00, 8'h02, 8'h02, "inc_zero");
`else
        read_back(8'hFF, 8'h02, 8'h00, "inc_top");
        read_back(8'h00, 8'h5A, 8'h5A, "inc_zero");
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
